// File: rtl/uart_tx_stream_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// uart_tx_stream_arbiter_pkg
// Shared definitions for the UART TX stream arbiter:
//   - arbiter FSM state encoding
//   - one-hot grant encodings
//   - ASCII line-control constants and the default burst terminator
// No ports; imported by uart_tx_stream_arbiter and its bench.
// ---------------------------------------------------------------------------
package uart_tx_stream_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } arb_state_t;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_P0   = 2'b01;
  localparam logic [1:0] GRANT_P1   = 2'b10;

  localparam logic [7:0] CHAR_LF           = 8'h0A;
  localparam logic [7:0] CHAR_CR           = 8'h0D;
  localparam logic [7:0] TERM_BYTE_DEFAULT = CHAR_LF;

  // Port index -> one-hot grant vector.
  function automatic logic [1:0] grant_onehot(input logic port);
    return port ? GRANT_P1 : GRANT_P0;
  endfunction

endpackage

// File: rtl/uart_tx_stream_arbiter_stream_out_reg.sv
// ---------------------------------------------------------------------------
// stream_out_reg
// Single-entry registered valid/ready stage. Accepts a word whenever the
// register is empty or is being drained in the same cycle, so back-to-back
// transfers sustain one word per clock while out_ready stays high.
// Ports:
//   clk        in   1       clock
//   rst_n      in   1       asynchronous active-low reset (clears held word)
//   in_data    in   DATA_W  upstream word
//   in_valid   in   1       upstream valid
//   in_ready   out  1       upstream ready (combinational)
//   out_data   out  DATA_W  registered word
//   out_valid  out  1       registered valid
//   out_ready  in   1       downstream ready
// ---------------------------------------------------------------------------
module stream_out_reg #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  logic [DATA_W-1:0] data_p1;
  logic              vld_p1;

  assign in_ready  = !vld_p1 || out_ready;
  assign out_data  = data_p1;
  assign out_valid = vld_p1;

  // Stage p0 -> p1: capture on accept, otherwise drain when downstream takes it.
  // The data register is cleared on reset too, so the UART never sees a stale
  // byte on its data lines after a reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
    end else if (in_valid && in_ready) begin
      vld_p1  <= 1'b1;
      data_p1 <= in_data;
    end else if (out_ready) begin
      vld_p1  <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_tx_stream_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_stream_arbiter
// Shares the single UART TX byte stream between two sources:
//   port 0 = USB CDC OUT data, port 1 = local status/message source.
// Burst-locked round-robin: once granted, a port keeps the UART until its
// burst ends (MAX_BURST bytes, terminator byte, or IDLE_TIMEOUT idle cycles),
// so text lines from the two sources never interleave. One registered
// output stage (stream_out_reg) feeds the UART s_axis input.
// Ports:
//   clk_i        in   1       system clock (48 MHz clk_pll)
//   rstn_i       in   1       asynchronous active-low reset
//   in0_data_i   in   DATA_W  port 0 byte
//   in0_valid_i  in   1       port 0 valid
//   in0_ready_o  out  1       port 0 ready
//   in1_data_i   in   DATA_W  port 1 byte
//   in1_valid_i  in   1       port 1 valid
//   in1_ready_o  out  1       port 1 ready
//   out_data_o   out  DATA_W  byte to UART TX
//   out_valid_o  out  1       byte valid to UART TX
//   out_ready_i  in   1       UART TX ready
//   grant_o      out  2       one-hot current grant (00 = none)
// ---------------------------------------------------------------------------
module uart_tx_stream_arbiter
  import uart_tx_stream_arbiter_pkg::*;
#(
  parameter int              DATA_W       = 8,
  parameter int unsigned     MAX_BURST    = 64,
  parameter int unsigned     IDLE_TIMEOUT = 480,
  parameter bit              TERM_EN      = 1'b1,
  parameter logic [DATA_W-1:0] TERM_BYTE  = DATA_W'(TERM_BYTE_DEFAULT)
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic [DATA_W-1:0] in0_data_i,
  input  logic              in0_valid_i,
  output logic              in0_ready_o,
  input  logic [DATA_W-1:0] in1_data_i,
  input  logic              in1_valid_i,
  output logic              in1_ready_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [1:0]        grant_o
);

  localparam int BURST_W = $clog2(MAX_BURST + 1);
  localparam int IDLE_W  = $clog2(IDLE_TIMEOUT + 1);

  // Saturating increment; the counters never need to exceed their limit
  // because reaching the limit releases the grant.
  function automatic int unsigned sat_inc(input int unsigned v, input int unsigned lim);
    if (v >= lim) return lim;
    return v + 1;
  endfunction

  arb_state_t           state, state_nxt;
  logic [1:0]           grant, grant_nxt;
  logic                 rr_last, rr_last_nxt;
  logic [BURST_W-1:0]   burst_cnt, burst_nxt;
  logic [IDLE_W-1:0]    idle_cnt, idle_nxt;

  logic                 gvalid;
  logic [DATA_W-1:0]    gdata;
  logic                 stage_ready;
  logic                 accept;
  logic                 rel_now;
  logic                 win;
  int unsigned          burst_inc;
  int unsigned          idle_inc;

  // Granted-port mux; grant is all-zero outside LOCK so nothing is
  // presented to the output stage while idle.
  always_comb begin
    gvalid = (grant[0] && in0_valid_i) || (grant[1] && in1_valid_i);
    gdata  = grant[1] ? in1_data_i : in0_data_i;
  end

  assign accept      = (state == ST_LOCK) && gvalid && stage_ready;
  assign in0_ready_o = grant[0] && stage_ready;
  assign in1_ready_o = grant[1] && stage_ready;
  assign grant_o     = grant;

  assign burst_inc = sat_inc(32'(burst_cnt), MAX_BURST);
  assign idle_inc  = sat_inc(32'(idle_cnt), IDLE_TIMEOUT);

  // Release is decided on the cycle of the last accept (or last idle cycle)
  // and takes effect on the following edge, independent of output drain.
  assign rel_now = (state == ST_LOCK) &&
                   ((accept && (burst_inc == MAX_BURST)) ||
                    (accept && TERM_EN && (gdata == TERM_BYTE)) ||
                    (!gvalid && (idle_inc == IDLE_TIMEOUT)));

  always_comb begin
    state_nxt   = state;
    grant_nxt   = grant;
    rr_last_nxt = rr_last;
    burst_nxt   = burst_cnt;
    idle_nxt    = idle_cnt;
    win         = 1'b0;

    case (state)
      ST_IDLE: begin
        burst_nxt = '0;
        idle_nxt  = '0;
        if (in0_valid_i || in1_valid_i) begin
          // Tie goes to the port that was not granted last.
          win       = (in0_valid_i && in1_valid_i) ? !rr_last : in1_valid_i;
          state_nxt = ST_LOCK;
          grant_nxt = grant_onehot(win);
        end
      end
      ST_LOCK: begin
        if (accept) begin
          burst_nxt = BURST_W'(burst_inc);
        end
        if (gvalid) begin
          idle_nxt = '0;
        end else begin
          idle_nxt = IDLE_W'(idle_inc);
        end
        if (rel_now) begin
          state_nxt   = ST_IDLE;
          grant_nxt   = GRANT_NONE;
          rr_last_nxt = grant[1];
          burst_nxt   = '0;
          idle_nxt    = '0;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        grant_nxt = GRANT_NONE;
      end
    endcase
  end

  // Arbiter control registers; reset favours port 0 (last grant = port 1).
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state     <= ST_IDLE;
      grant     <= GRANT_NONE;
      rr_last   <= 1'b1;
      burst_cnt <= '0;
      idle_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      grant     <= grant_nxt;
      rr_last   <= rr_last_nxt;
      burst_cnt <= burst_nxt;
      idle_cnt  <= idle_nxt;
    end
  end

  // Stage p0 -> p1: single registered output towards the UART.
  stream_out_reg #(
    .DATA_W(DATA_W)
  ) u_out_reg (
    .clk       (clk_i),
    .rst_n     (rstn_i),
    .in_data   (gdata),
    .in_valid  (gvalid),
    .in_ready  (stage_ready),
    .out_data  (out_data_o),
    .out_valid (out_valid_o),
    .out_ready (out_ready_i)
  );

  // Source-side protocol: a stalled valid must not drop and its data must hold.
  in0_hold_a: assert property (@(posedge clk_i) disable iff (!rstn_i)
    (in0_valid_i && !in0_ready_o) |=> (in0_valid_i && $stable(in0_data_i)));
  in1_hold_a: assert property (@(posedge clk_i) disable iff (!rstn_i)
    (in1_valid_i && !in1_ready_o) |=> (in1_valid_i && $stable(in1_data_i)));

endmodule

// File: tb/tb_uart_tx_stream_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_stream_arbiter
// Randomised bench for uart_tx_stream_arbiter. A burst-level reference model
// turns each pair of source byte lists into the expected UART byte order and
// pushes it to a queue; an independent monitor pops on every output handshake.
// ---------------------------------------------------------------------------
module tb_uart_tx_stream_arbiter;
  import uart_tx_stream_arbiter_pkg::*;

  localparam int          DATA_W       = 8;
  localparam int unsigned MAX_BURST    = 64;
  localparam int unsigned IDLE_TIMEOUT = 480;
  localparam int          BYTE_BUDGET  = 4000;

  typedef logic [7:0] byte_q_t[$];

  logic              clk_i = 1'b0;
  logic              rstn_i;
  logic [DATA_W-1:0] in0_data_i, in1_data_i;
  logic              in0_valid_i, in1_valid_i;
  logic              in0_ready_o, in1_ready_o;
  logic [DATA_W-1:0] out_data_o;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [1:0]        grant_o;

  int          n_cmp = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          ready_pct = 100;
  int          model_last = 1;
  int          last_acc1 = 0;
  logic [7:0]  exp_q[$];

  uart_tx_stream_arbiter #(
    .DATA_W(DATA_W), .MAX_BURST(MAX_BURST), .IDLE_TIMEOUT(IDLE_TIMEOUT),
    .TERM_EN(1'b1), .TERM_BYTE(CHAR_LF)
  ) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .in0_data_i(in0_data_i), .in0_valid_i(in0_valid_i), .in0_ready_o(in0_ready_o),
    .in1_data_i(in1_data_i), .in1_valid_i(in1_valid_i), .in1_ready_o(in1_ready_o),
    .out_data_o(out_data_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .grant_o(grant_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic sync();
    @(posedge clk_i);
    #1;
  endtask

  // Reference model: bursts alternate between ports with data, ties going to
  // the port not served last; a burst ends after MAX_BURST bytes, after LF,
  // or when its source has nothing more to send.
  task automatic model_push(input byte_q_t q0, input byte_q_t q1);
    int i0, i1, p, n;
    bit stop;
    logic [7:0] b;
    i0 = 0;
    i1 = 0;
    while (i0 < q0.size() || i1 < q1.size()) begin
      if (i0 < q0.size() && i1 < q1.size()) p = 1 - model_last;
      else if (i0 < q0.size()) p = 0;
      else p = 1;
      n = 0;
      stop = 0;
      while (!stop) begin
        if (p == 0) begin
          b = q0[i0]; i0++; stop = (i0 >= q0.size());
        end else begin
          b = q1[i1]; i1++; stop = (i1 >= q1.size());
        end
        exp_q.push_back(b);
        n++;
        if (n == MAX_BURST || b == CHAR_LF) stop = 1;
      end
      model_last = p;
    end
  endtask

  function automatic byte_q_t make_bytes(input int len, input int lf_pct);
    byte_q_t q;
    logic [7:0] b;
    for (int i = 0; i < len; i++) begin
      if ($urandom_range(0, 99) < lf_pct) b = CHAR_LF;
      else begin
        b = 8'($urandom_range(0, 255));
        if (b == CHAR_LF) b = 8'h0B;
      end
      q.push_back(b);
    end
    return q;
  endfunction

  // Source driver: presents each byte until accepted, next byte in the same cycle.
  task automatic send(input int p, input byte_q_t b);
    int n;
    bit ok;
    foreach (b[i]) begin
      if (p == 0) begin in0_data_i = b[i]; in0_valid_i = 1'b1; end
      else        begin in1_data_i = b[i]; in1_valid_i = 1'b1; end
      n = 0;
      ok = 0;
      while (!ok && n < BYTE_BUDGET) begin
        @(negedge clk_i);
        if ((p == 0) ? in0_ready_o : in1_ready_o) ok = 1;
        else n++;
      end
      if (!ok) begin
        n_cmp++;
        n_fail++;
        $display("FAIL accept_timeout: port %0d byte %0d not accepted, required within %0d cycles",
                 p, i, BYTE_BUDGET);
        break;
      end
      @(posedge clk_i);
      #1;
      if (p == 1) last_acc1 = cyc;
    end
    if (p == 0) in0_valid_i = 1'b0;
    else        in1_valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(grant_o == GRANT_NONE && !out_valid_o && exp_q.size() == 0) && n < 3000) begin
      @(negedge clk_i);
      n++;
    end
    check("release_and_drain", 32'(n < 3000), 32'd1);
    sync();
  endtask

  task automatic run_scenario(input byte_q_t q0, input byte_q_t q1);
    model_push(q0, q1);
    fork
      send(0, q0);
      send(1, q1);
    join
    wait_idle();
  endtask

  // UART-side ready pattern, re-drawn every cycle.
  initial begin
    out_ready_i = 1'b1;
    forever begin
      @(posedge clk_i);
      #1;
      out_ready_i = ($urandom_range(0, 99) < ready_pct);
    end
  end

  // Monitor: scoreboard pop on handshake, stall stability and ready gating.
  initial begin
    logic       prev_stall;
    logic [7:0] prev_data;
    logic [7:0] e;
    prev_stall = 0;
    prev_data  = '0;
    forever begin
      @(negedge clk_i);
      if (!rstn_i) begin
        prev_stall = 0;
      end else begin
        if (prev_stall)
          check("stall_hold", 32'({out_valid_o, out_data_o}), 32'({1'b1, prev_data}));
        if (out_valid_o && !out_ready_i)
          check("stall_ready_low", 32'({in0_ready_o, in1_ready_o}), 32'd0);
        if (out_valid_o && out_ready_i) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_byte: got %h, expected no output", out_data_o);
          end else begin
            e = exp_q.pop_front();
            check("out_byte", 32'(out_data_o), 32'(e));
          end
        end
        prev_stall = out_valid_o && !out_ready_i;
        prev_data  = out_data_o;
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish, required completion before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    byte_q_t q0, q1;
    int      n;
    bit      done1;
    int      pcts[6] = '{30, 100, 60, 30, 80, 100};

    rstn_i = 1'b1;
    in0_valid_i = 1'b0; in1_valid_i = 1'b0;
    in0_data_i = '0;    in1_data_i = '0;
    #1;
    rstn_i = 1'b0;
    in0_valid_i = 1'b1; in1_valid_i = 1'b1;
    in0_data_i = 8'h33; in1_data_i = 8'h44;
    repeat (5) begin
      @(negedge clk_i);
      check("reset_state", 32'({in0_ready_o, in1_ready_o, out_valid_o, grant_o, out_data_o}), 32'd0);
    end
    in0_valid_i = 1'b0; in1_valid_i = 1'b0;
    sync();
    rstn_i = 1'b1;
    sync();

    // 100 bytes each without LF: 64/64/36/36 bursts, port 0 first.
    run_scenario(make_bytes(100, 0), make_bytes(100, 0));

    // "AB\n" from port 0 alone with exact timing.
    q0 = '{8'h41, 8'h42, 8'h0A};
    q1 = {};
    model_push(q0, q1);
    fork
      send(0, q0);
      begin
        @(negedge clk_i); check("ab_idle_cycle", 32'(grant_o), 32'(GRANT_NONE));
        @(negedge clk_i); check("ab_grant", 32'(grant_o), 32'(GRANT_P0));
        @(negedge clk_i); check("ab_byte_a", 32'({out_valid_o, out_data_o}), 32'h141);
        @(negedge clk_i); check("ab_byte_b", 32'({out_valid_o, out_data_o}), 32'h142);
        @(negedge clk_i); check("ab_byte_lf", 32'({out_valid_o, out_data_o}), 32'h10A);
        check("ab_release", 32'(grant_o), 32'(GRANT_NONE));
      end
    join
    wait_idle();

    // Timeout: port 1 wins the tie, sends 3 bytes, idles; port 0 waits.
    q1 = make_bytes(3, 0);
    q0 = make_bytes(2, 0);
    model_push(q0, q1);
    done1 = 0;
    fork
      begin send(1, q1); done1 = 1; end
      send(0, q0);
      begin
        n = 0;
        while (!done1 && n < BYTE_BUDGET) begin @(negedge clk_i); n++; end
        check("timeout_port1_done", 32'(done1), 32'd1);
        if (done1) begin
          while (cyc < last_acc1 + int'(IDLE_TIMEOUT) - 1) @(negedge clk_i);
          check("timeout_still_locked", 32'(grant_o), 32'(GRANT_P1));
          @(negedge clk_i); check("timeout_release", 32'(grant_o), 32'(GRANT_NONE));
          @(negedge clk_i); check("timeout_regrant_p0", 32'(grant_o), 32'(GRANT_P0));
        end
      end
    join
    wait_idle();

    // Random traffic with terminators and varying UART backpressure.
    for (int s = 0; s < 6; s++) begin
      ready_pct = pcts[s];
      run_scenario(make_bytes($urandom_range(0, 90), 8), make_bytes($urandom_range(0, 90), 8));
    end

    // Reset while a byte is held by a stalled UART.
    ready_pct = 0;
    repeat (2) sync();
    in0_data_i = 8'h55;
    in0_valid_i = 1'b1;
    repeat (4) sync();
    @(negedge clk_i);
    check("held_before_reset", 32'({out_valid_o, out_data_o}), 32'h155);
    #2;
    rstn_i = 1'b0;
    #1;
    check("async_reset_drop", 32'({out_valid_o, out_data_o, grant_o, in0_ready_o}), 32'd0);
    in0_valid_i = 1'b0;
    repeat (3) sync();
    rstn_i = 1'b1;
    model_last = 1;
    ready_pct = 100;
    sync();
    q0 = make_bytes($urandom_range(1, 20), 0);
    q1 = make_bytes($urandom_range(1, 20), 0);
    model_push(q0, q1);
    fork
      send(0, q0);
      send(1, q1);
      begin
        n = 0;
        while (grant_o == GRANT_NONE && n < 10) begin @(negedge clk_i); n++; end
        check("restart_grant_p0", 32'(grant_o), 32'(GRANT_P0));
      end
    join
    wait_idle();

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
